// File: rtl/player_input_ctrl.sv
// player_input_ctrl: turns raw board push-buttons and slide switches into
// clean one-per-press game events offered over a valid/ready handshake.
//
// Ports:
//   CLOCK_50   system clock, rising edge
//   reset      synchronous active-high reset
//   key_n[2:0] raw KEY[3:1], active-low, async (bit0=KEY1 start, bit1=KEY2, bit2=KEY3)
//   sw         raw slide switches, async
//   evt_valid  event offered to the game-mode FSM
//   evt_ready  consumer accepts the event
//   evt_type   0=START, 1=PICK_FIRST, 2=PICK_SECOND
//   evt_tile   index of the single raised switch (0 for START)
//   err_none   1-cycle pulse: pick press with no switch up
//   err_multi  1-cycle pulse: pick press with more than one switch up
//   overrun    sticky: a press was lost
module player_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NUM_TILES       = 10,
    parameter int unsigned IDX_W           = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [2:0]           key_n,
    input  logic [NUM_TILES-1:0] sw,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [1:0]           evt_type,
    output logic [IDX_W-1:0]     evt_tile,
    output logic                 err_none,
    output logic                 err_multi,
    output logic                 overrun
);

    localparam int unsigned NUM_KEYS = 3;
    localparam int unsigned CNT_W    = 4;

    localparam logic [1:0] EVT_START       = 2'd0;
    localparam logic [1:0] EVT_PICK_FIRST  = 2'd1;
    localparam logic [1:0] EVT_PICK_SECOND = 2'd2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Input conditioning state
    logic [NUM_KEYS-1:0]  key_meta;
    logic [NUM_KEYS-1:0]  key_sync;
    logic [NUM_TILES-1:0] sw_meta;
    logic [NUM_TILES-1:0] sw_sync;
    logic [NUM_KEYS-1:0]  key_stable;
    logic [NUM_KEYS-1:0]  key_stable_d;
    logic [CNT_W-1:0]     key_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0]  press_q;

    // Handshake state and next-state values
    state_t           state;
    state_t           state_d;
    logic [1:0]       evt_type_d;
    logic [IDX_W-1:0] evt_tile_d;
    logic             err_none_d;
    logic             err_multi_d;
    logic             overrun_d;

    // Switch decode and press arbitration
    logic             sw_found;
    logic             sw_multi;
    logic [IDX_W-1:0] sw_idx;
    logic             press_any;
    logic             press_extra;
    logic [1:0]       press_type;
    logic             new_evt;
    logic             transfer;

    assign evt_valid = (state == ST_FULL);

    // Synchronizers, per-key debounce, and registered press strobe
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_meta     <= '1;
            key_sync     <= '1;
            sw_meta      <= '0;
            sw_sync      <= '0;
            key_stable   <= '1;
            key_stable_d <= '1;
            press_q      <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_cnt[k] <= '0;
            end
        end else begin
            key_meta     <= key_n;
            key_sync     <= key_meta;
            sw_meta      <= sw;
            sw_sync      <= sw_meta;
            key_stable_d <= key_stable;
            // Falling edge of the debounced level, delayed one cycle
            press_q      <= key_stable_d & ~key_stable;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_sync[k] == key_stable[k]) begin
                    key_cnt[k] <= '0;
                end else if (key_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_stable[k] <= key_sync[k];
                    key_cnt[k]    <= '0;
                end else begin
                    key_cnt[k] <= key_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= ST_EMPTY;
            evt_type  <= '0;
            evt_tile  <= '0;
            err_none  <= 1'b0;
            err_multi <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            evt_type  <= evt_type_d;
            evt_tile  <= evt_tile_d;
            err_none  <= err_none_d;
            err_multi <= err_multi_d;
            overrun   <= overrun_d;
        end
    end

    // Next-state: switch validation, key priority, handshake
    always_comb begin
        sw_found    = 1'b0;
        sw_multi    = 1'b0;
        sw_idx      = '0;
        press_any   = 1'b0;
        press_extra = 1'b0;
        press_type  = EVT_START;
        new_evt     = 1'b0;
        transfer    = 1'b0;
        state_d     = state;
        evt_type_d  = evt_type;
        evt_tile_d  = evt_tile;
        err_none_d  = 1'b0;
        err_multi_d = 1'b0;
        overrun_d   = overrun;

        for (int i = 0; i < NUM_TILES; i++) begin
            if (sw_sync[i]) begin
                if (sw_found) begin
                    sw_multi = 1'b1;
                end
                sw_found = 1'b1;
                sw_idx   = IDX_W'(i);
            end
        end

        // KEY1 > KEY2 > KEY3; losers count as lost presses
        if (press_q[0]) begin
            press_any   = 1'b1;
            press_type  = EVT_START;
            press_extra = press_q[1] | press_q[2];
        end else if (press_q[1]) begin
            press_any   = 1'b1;
            press_type  = EVT_PICK_FIRST;
            press_extra = press_q[2];
        end else if (press_q[2]) begin
            press_any   = 1'b1;
            press_type  = EVT_PICK_SECOND;
        end

        if (press_any) begin
            if (press_type == EVT_START) begin
                new_evt = 1'b1;
            end else if (!sw_found) begin
                err_none_d = 1'b1;
            end else if (sw_multi) begin
                err_multi_d = 1'b1;
            end else begin
                new_evt = 1'b1;
            end
        end

        if (press_extra) begin
            overrun_d = 1'b1;
        end

        transfer = (state == ST_FULL) && evt_ready;

        case (state)
            ST_EMPTY: begin
                if (new_evt) begin
                    state_d    = ST_FULL;
                    evt_type_d = press_type;
                    evt_tile_d = (press_type == EVT_START) ? '0 : sw_idx;
                end
            end
            ST_FULL: begin
                if (transfer) begin
                    if (new_evt) begin
                        evt_type_d = press_type;
                        evt_tile_d = (press_type == EVT_START) ? '0 : sw_idx;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (new_evt) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: table of single-press scenarios plus
// hand-written multi-cycle sequences for handshake, overrun and reset cases.
module tb_player_input_ctrl;

    localparam int unsigned NUM_TILES = 10;
    localparam int unsigned IDX_W     = 4;
    localparam int          WINDOW    = 40;
    localparam int          NUM_VECS  = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           key_n;
    logic [NUM_TILES-1:0] sw;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [1:0]           evt_type;
    logic [IDX_W-1:0]     evt_tile;
    logic                 err_none;
    logic                 err_multi;
    logic                 overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .NUM_TILES      (NUM_TILES),
        .IDX_W          (IDX_W)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .key_n    (key_n),
        .sw       (sw),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_type (evt_type),
        .evt_tile (evt_tile),
        .err_none (err_none),
        .err_multi(err_multi),
        .overrun  (overrun)
    );

    typedef struct {
        string      name;
        logic [2:0] key_low;   // key_n value while pressed
        int         low_cycles;
        logic [9:0] sw_val;
        int         exp_nvalid;
        int         exp_first;
        int         exp_type;
        int         exp_tile;
        int         exp_enone;
        int         exp_emulti;
    } vec_t;

    vec_t vecs [NUM_VECS];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        key_n     = 3'b111;
        evt_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Drive one press (iteration c drives the value sampled by edge c) and observe
    task automatic run_press(input logic [2:0] kval, input int low, input int win,
                             output int nvalid, output int first, output int ty,
                             output int ti, output int nen, output int nem);
        nvalid = 0; first = -1; ty = -1; ti = -1; nen = 0; nem = 0;
        for (int c = 0; c < win; c++) begin
            key_n = (c < low) ? kval : 3'b111;
            step();
            if (evt_valid) begin
                if (nvalid == 0) begin
                    first = c;
                    ty    = int'(evt_type);
                    ti    = int'(evt_tile);
                end
                nvalid++;
            end
            if (err_none)  nen++;
            if (err_multi) nem++;
        end
    endtask

    initial begin
        int nvalid, first, ty, ti, nen, nem, xfer;
        bit stable_ok;

        vecs[0] = '{"start",        3'b110,  7, 10'b0000000000, 1, 7, 0, 0, 0, 0};
        vecs[1] = '{"pick1_t3",     3'b101, 10, 10'b0000001000, 1, 7, 1, 3, 0, 0};
        vecs[2] = '{"pick2_t0",     3'b011, 10, 10'b0000000001, 1, 7, 2, 0, 0, 0};
        vecs[3] = '{"pick2_multi",  3'b011, 10, 10'b0000000011, 0, -1, -1, -1, 0, 1};
        vecs[4] = '{"pick1_none",   3'b101, 10, 10'b0000000000, 0, -1, -1, -1, 1, 0};
        vecs[5] = '{"glitch2",      3'b011,  2, 10'b0000000000, 0, -1, -1, -1, 0, 0};
        vecs[6] = '{"glitch3",      3'b101,  3, 10'b0000000000, 0, -1, -1, -1, 0, 0};
        vecs[7] = '{"min_press4",   3'b110,  4, 10'b0000000000, 1, 7, 0, 0, 0, 0};
        vecs[8] = '{"pick1_t9",     3'b101, 21, 10'b1000000000, 1, 7, 1, 9, 0, 0};
        vecs[9] = '{"start_ign_sw", 3'b110, 10, 10'b0101000000, 1, 7, 0, 0, 0, 0};

        sw = '0;
        do_reset();
        chk("rst_valid",   int'(evt_valid), 0);
        chk("rst_type",    int'(evt_type),  0);
        chk("rst_tile",    int'(evt_tile),  0);
        chk("rst_enone",   int'(err_none),  0);
        chk("rst_emulti",  int'(err_multi), 0);
        chk("rst_overrun", int'(overrun),   0);

        // Table-driven single presses with evt_ready held high
        for (int v = 0; v < NUM_VECS; v++) begin
            sw = vecs[v].sw_val;
            do_reset();
            evt_ready = 1'b1;
            run_press(vecs[v].key_low, vecs[v].low_cycles, WINDOW,
                      nvalid, first, ty, ti, nen, nem);
            chk({vecs[v].name, "_nvalid"},  nvalid, vecs[v].exp_nvalid);
            chk({vecs[v].name, "_first"},   first,  vecs[v].exp_first);
            chk({vecs[v].name, "_type"},    ty,     vecs[v].exp_type);
            chk({vecs[v].name, "_tile"},    ti,     vecs[v].exp_tile);
            chk({vecs[v].name, "_enone"},   nen,    vecs[v].exp_enone);
            chk({vecs[v].name, "_emulti"},  nem,    vecs[v].exp_emulti);
            chk({vecs[v].name, "_overrun"}, int'(overrun), 0);
        end

        // Key held low through reset release is a single press
        sw = '0;
        reset = 1'b1; key_n = 3'b110; evt_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        run_press(3'b110, 12, WINDOW, nvalid, first, ty, ti, nen, nem);
        chk("held_rst_nvalid", nvalid, 1);
        chk("held_rst_first",  first,  7);
        chk("held_rst_type",   ty,     0);

        // Backpressure: payload held until the single transfer
        sw = 10'b0010000000;
        do_reset();
        first = -1; nvalid = 0; xfer = 0; stable_ok = 1'b1;
        for (int c = 0; c < WINDOW; c++) begin
            key_n     = (c < 21) ? 3'b101 : 3'b111;
            evt_ready = (c >= 10);
            if (evt_valid && evt_ready) xfer++;
            step();
            if (evt_valid) begin
                if (first < 0) first = c;
                nvalid++;
                if (evt_type != 2'd1 || evt_tile != 4'd7) stable_ok = 1'b0;
            end
        end
        chk("bp_first",     first,           7);
        chk("bp_nvalid",    nvalid,          3);
        chk("bp_stable",    int'(stable_ok), 1);
        chk("bp_transfers", xfer,            1);

        // Simultaneous KEY2/KEY3, then KEY1 dropped while FULL
        sw = 10'b1000000000;
        do_reset();
        nen = 0; nem = 0;
        for (int c = 0; c < 30; c++) begin
            key_n = 3'b111;
            if (c < 10) key_n = 3'b001;
            if (c >= 12 && c < 20) key_n = 3'b110;
            step();
            if (err_none)  nen++;
            if (err_multi) nem++;
            if (c == 7) begin
                chk("sim_valid7",   int'(evt_valid), 1);
                chk("sim_type7",    int'(evt_type),  1);
                chk("sim_tile7",    int'(evt_tile),  9);
                chk("sim_overrun7", int'(overrun),   1);
            end
        end
        chk("drop_valid",   int'(evt_valid), 1);
        chk("drop_type",    int'(evt_type),  1);
        chk("drop_tile",    int'(evt_tile),  9);
        chk("drop_overrun", int'(overrun),   1);
        chk("sim_errs",     nen + nem,       0);

        // Reset mid-handshake drops the event and clears overrun
        evt_ready = 1'b1;
        reset     = 1'b1;
        step();
        chk("midrst_valid",   int'(evt_valid), 0);
        chk("midrst_overrun", int'(overrun),   0);
        reset = 1'b0;
        step();
        chk("postrst_valid", int'(evt_valid), 0);
        run_press(3'b110, 7, WINDOW, nvalid, first, ty, ti, nen, nem);
        chk("postrst_nvalid", nvalid, 1);
        chk("postrst_first",  first,  7);
        chk("postrst_type",   ty,     0);
        chk("postrst_tile",   ti,     0);

        // Transfer coinciding with a new press reloads without a bubble
        sw = 10'b0010000000;
        do_reset();
        xfer = 0;
        for (int c = 0; c < 35; c++) begin
            key_n = 3'b111;
            if (c < 25) key_n[1] = 1'b0;
            if (c >= 10 && c < 25) key_n[2] = 1'b0;
            evt_ready = (c == 17) || (c >= 22);
            if (evt_valid && evt_ready) xfer++;
            step();
            if (c == 16) begin
                chk("nb_type16",  int'(evt_type),  1);
                chk("nb_valid16", int'(evt_valid), 1);
            end
            if (c == 17) begin
                chk("nb_valid17",   int'(evt_valid), 1);
                chk("nb_type17",    int'(evt_type),  2);
                chk("nb_tile17",    int'(evt_tile),  7);
                chk("nb_overrun17", int'(overrun),   0);
            end
        end
        chk("nb_transfers", xfer,            2);
        chk("nb_end_valid", int'(evt_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
